// File: rtl/direction_input_queue.sv
// Snake direction front end: synchronises and debounces four raw direction
// buttons, turns each debounced press into a one-cycle event, filters the
// event against the last queued heading and buffers accepted turns in a
// small FIFO that the game tick drains one entry per move.
module direction_input_queue #(
  parameter int DEBOUNCE_CYCLES = 327680,
  parameter int CNT_WIDTH       = 20,
  parameter int QUEUE_DEPTH     = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             btn_up,
  input  logic                             btn_right,
  input  logic                             btn_down,
  input  logic                             btn_left,
  input  logic                             step,
  output logic [1:0]                       direction,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] q_count,
  output logic [3:0]                       press_evt,
  output logic                             turn_dropped
);

  localparam int QCNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [QCNT_W-1:0]    Q_FULL   = QCNT_W'(QUEUE_DEPTH);
  localparam logic [1:0]           DIR_RESET = 2'b01;

  // Channel order everywhere: bit 0 up, 1 right, 2 down, 3 left. The bit
  // index doubles as the heading code, so a candidate is just its index.
  logic [3:0]           btn_raw;
  logic [3:0]           sync_p0;
  logic [3:0]           sync_p1;
  logic [3:0]           stable;
  logic [3:0]           stable_last;
  logic [CNT_WIDTH-1:0] db_cnt [4];

  logic [1:0]           fifo_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     tail_ptr;

  logic [1:0]           cand_dir;
  logic [1:0]           ref_dir;
  logic                 evt_any;
  logic                 is_same;
  logic                 is_opp;
  logic                 q_full;
  logic                 pop;
  logic                 push;
  logic                 drop_nxt;

  assign btn_raw = {btn_left, btn_down, btn_right, btn_up};

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_prev(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_LAST : p - PTR_W'(1);
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: stable follows sync only after DEBOUNCE_CYCLES consecutive
  // disagreeing cycles; any agreeing cycle restarts the count from zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= '0;
      for (int ch = 0; ch < 4; ch++) begin
        db_cnt[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < 4; ch++) begin
        if (sync_p1[ch] == stable[ch]) begin
          db_cnt[ch] <= '0;
        end else if (db_cnt[ch] == CNT_LAST) begin
          stable[ch] <= sync_p1[ch];
          db_cnt[ch] <= '0;
        end else begin
          db_cnt[ch] <= db_cnt[ch] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Rising-edge detect on the debounced level; releases are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_last <= '0;
      press_evt   <= '0;
    end else begin
      stable_last <= stable;
      press_evt   <= stable & ~stable_last;
    end
  end

  // Acceptance: pick one candidate by priority and judge it against the
  // newest queued heading (or the live heading when nothing is queued)
  always_comb begin
    cand_dir = 2'b11;
    if (press_evt[0]) begin
      cand_dir = 2'b00;
    end else if (press_evt[1]) begin
      cand_dir = 2'b01;
    end else if (press_evt[2]) begin
      cand_dir = 2'b10;
    end

    tail_ptr = ptr_prev(wr_ptr);
    ref_dir  = (q_count != '0) ? fifo_mem[tail_ptr] : direction;

    evt_any  = |press_evt;
    is_same  = (cand_dir == ref_dir);
    is_opp   = (cand_dir == (ref_dir ^ 2'b10));
    q_full   = (q_count == Q_FULL);
    pop      = step && (q_count != '0);
    // A full queue still takes the turn when the tick frees a slot now
    push     = evt_any && !is_same && !is_opp && (!q_full || pop);
    drop_nxt = evt_any && !is_same && (is_opp || (q_full && !pop));
  end

  // Queue control and heading: pop loads the head into direction, push
  // advances the tail; there is no bypass from a push to direction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      q_count      <= '0;
      direction    <= DIR_RESET;
      turn_dropped <= 1'b0;
    end else begin
      turn_dropped <= drop_nxt;
      if (pop) begin
        direction <= fifo_mem[rd_ptr];
        rd_ptr    <= ptr_next(rd_ptr);
      end
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (push && !pop) begin
        q_count <= q_count + QCNT_W'(1);
      end else if (pop && !push) begin
        q_count <= q_count - QCNT_W'(1);
      end
    end
  end

  // Queue storage; entries are only read while counted as valid
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= cand_dir;
    end
  end

endmodule

// File: tb/tb_direction_input_queue.sv
// Bench for direction_input_queue with a short debounce and a 2-entry queue.
module tb_direction_input_queue;

  localparam int D  = 4;
  localparam int QD = 2;
  localparam int QW = $clog2(QD + 1);

  logic          clk;
  logic          reset;
  logic [3:0]    btn;
  logic          step;
  logic [1:0]    direction;
  logic [QW-1:0] q_count;
  logic [3:0]    press_evt;
  logic          turn_dropped;

  int tests  = 0;
  int failed = 0;
  int drop_flag = 0;
  int evt_cnt = 0;

  direction_input_queue #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH(4),
    .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btn[0]),
    .btn_right(btn[1]),
    .btn_down(btn[2]),
    .btn_left(btn[3]),
    .step(step),
    .direction(direction),
    .q_count(q_count),
    .press_evt(press_evt),
    .turn_dropped(turn_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Raw button history since reset; the synchronised value seen at edge e
  // is the raw value sampled two edges earlier. A channel's stable level
  // flips at edge e when the last D synchronised samples all disagree with
  // it and no flip happened inside that window.
  logic [3:0] rawh[$];
  logic [3:0] m_stable, m_rise, m_press;
  int         m_flip[4];
  logic [1:0] mq[$];
  logic [1:0] m_dir;
  logic       m_drop;

  function automatic void model_reset();
    rawh.delete();
    mq.delete();
    m_stable = '0;
    m_rise   = '0;
    m_press  = '0;
    m_dir    = 2'b01;
    m_drop   = 1'b0;
    for (int c = 0; c < 4; c++) m_flip[c] = -1;
  endfunction

  function automatic logic [3:0] sync_at(input int e);
    if (e >= 2) return rawh[e-2];
    return 4'b0000;
  endfunction

  function automatic void model_edge(input logic [3:0] raw, input logic st);
    int         e;
    logic [3:0] new_stable;
    logic [3:0] s;
    logic [1:0] cand, refd;
    bit         ok, pop, push, drop;
    e = rawh.size();
    rawh.push_back(raw);
    // turn acceptance on the event visible before this edge
    cand = 2'b00;
    refd = (mq.size() > 0) ? mq[$] : m_dir;
    for (int b = 3; b >= 0; b--) if (m_press[b]) cand = 2'(b);
    pop  = st && (mq.size() > 0);
    push = 0;
    drop = 0;
    if (m_press != 0) begin
      if (cand == refd) begin
      end else if (cand == (refd ^ 2'b10)) drop = 1;
      else if (mq.size() == QD && !pop) drop = 1;
      else push = 1;
    end
    if (pop) m_dir = mq.pop_front();
    if (push) mq.push_back(cand);
    m_drop = drop;
    // debounce
    new_stable = m_stable;
    for (int c = 0; c < 4; c++) begin
      if (e - m_flip[c] >= D) begin
        ok = 1;
        for (int k = 0; k < D; k++) begin
          s = sync_at(e - k);
          if (s[c] == m_stable[c]) ok = 0;
        end
        if (ok) begin
          new_stable[c] = ~m_stable[c];
          m_flip[c] = e;
        end
      end
    end
    m_press  = m_rise;
    m_rise   = new_stable & ~m_stable;
    m_stable = new_stable;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    if (!reset) model_reset();
    else model_edge(btn, step);
    @(posedge clk);
    #1;
    check("cyc_dir", 32'(direction), 32'(m_dir));
    check("cyc_q", 32'(q_count), 32'(mq.size()));
    check("cyc_press", 32'(press_evt), 32'(m_press));
    check("cyc_drop", 32'(turn_dropped), 32'(m_drop));
    if (turn_dropped) drop_flag = 1;
    if (press_evt != 0) evt_cnt++;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  task automatic press(input logic [3:0] v);
    drop_flag = 0;
    btn = v;
    repeat (10) tick();
    btn = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
  endtask

  task automatic run_stage(input logic [3:0] b, input logic s);
    if (b != 4'b0000) press(b);
    if (s) pulse_step();
  endtask

  typedef struct {
    string      name;
    logic [3:0] b0;
    logic       s0;
    logic [3:0] b1;
    logic       s1;
    logic [3:0] b2;
    logic       s2;
    logic [1:0] exp_dir;
    int         exp_q;
    int         exp_drop;
  } case_t;

  case_t cases[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_at;
    int found;
    reset = 1'b0;
    btn   = 4'b0000;
    step  = 1'b0;
    model_reset();

    cases[0]  = '{"push_up",      4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b01, 1, 0};
    cases[1]  = '{"up_step",      4'b0001, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00, 0, 0};
    cases[2]  = '{"up_left",      4'b0001, 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'b01, 2, 0};
    cases[3]  = '{"left_opp",     4'b1000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b01, 0, 1};
    cases[4]  = '{"right_same",   4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b01, 0, 0};
    cases[5]  = '{"full_drop",    4'b0001, 1'b0, 4'b1000, 1'b0, 4'b0100, 1'b0, 2'b01, 2, 1};
    cases[6]  = '{"tail_opp",     4'b0001, 1'b0, 4'b1000, 1'b0, 4'b0010, 1'b0, 2'b01, 2, 1};
    cases[7]  = '{"dir_opp",      4'b0001, 1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'b00, 0, 1};
    cases[8]  = '{"prio_up",      4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b01, 1, 0};
    cases[9]  = '{"two_steps",    4'b0001, 1'b1, 4'b1000, 1'b1, 4'b0000, 1'b0, 2'b11, 0, 0};
    cases[10] = '{"prio_opp",     4'b0100, 1'b1, 4'b0011, 1'b0, 4'b0000, 1'b0, 2'b10, 0, 1};
    cases[11] = '{"up_left_step", 4'b0001, 1'b0, 4'b1000, 1'b1, 4'b0000, 1'b0, 2'b00, 1, 0};
    cases[12] = '{"tail_up_down", 4'b0001, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'b01, 1, 1};

    // reset and idle
    apply_reset();
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle_outputs", 32'({direction, q_count, press_evt, turn_dropped}),
            32'({2'b01, QW'(0), 4'b0000, 1'b0}));
    end

    // latency and single event for a held button, then step
    btn = 4'b0001;
    first_at = 0;
    evt_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (press_evt[0] && first_at == 0) first_at = i;
    end
    check("press_latency_in_6_to_8", 32'(first_at >= 6 && first_at <= 8), 32'd1);
    check("held_single_event", 32'(evt_cnt), 32'd1);
    check("held_q_one", 32'(q_count), 32'd1);
    btn = 4'b0000;
    pulse_step();
    check("held_step_dir", 32'(direction), 32'(2'b00));
    check("held_step_q", 32'(q_count), 32'd0);

    // glitch then genuine press
    apply_reset();
    evt_cnt = 0;
    btn = 4'b0001;
    repeat (3) tick();
    btn = 4'b0000;
    repeat (12) tick();
    check("glitch_no_event", 32'(evt_cnt), 32'd0);
    btn = 4'b0001;
    repeat (10) tick();
    btn = 4'b0000;
    repeat (8) tick();
    check("after_glitch_one_event", 32'(evt_cnt), 32'd1);

    // acceptance table
    for (int i = 0; i < 13; i++) begin
      apply_reset();
      run_stage(cases[i].b0, cases[i].s0);
      run_stage(cases[i].b1, cases[i].s1);
      run_stage(cases[i].b2, cases[i].s2);
      check({cases[i].name, "_dir"}, 32'(direction), 32'(cases[i].exp_dir));
      check({cases[i].name, "_q"}, 32'(q_count), 32'(cases[i].exp_q));
      check({cases[i].name, "_drop"}, 32'(drop_flag), 32'(cases[i].exp_drop));
    end

    // full queue, step in the press_evt cycle: push and pop together
    apply_reset();
    press(4'b0001);
    press(4'b1000);
    check("fullpop_pre_q", 32'(q_count), 32'd2);
    btn = 4'b0100;
    found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      tick();
      if (press_evt[2]) found = 1;
    end
    check("fullpop_evt_seen", 32'(found), 32'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("fullpop_q", 32'(q_count), 32'd2);
    check("fullpop_dir", 32'(direction), 32'(2'b00));
    check("fullpop_nodrop", 32'(turn_dropped), 32'd0);
    btn = 4'b0000;
    repeat (8) tick();
    pulse_step();
    check("fullpop_dir2", 32'(direction), 32'(2'b11));
    pulse_step();
    check("fullpop_tail_down", 32'(direction), 32'(2'b10));
    check("fullpop_empty", 32'(q_count), 32'd0);

    // asynchronous reset mid-debounce with a non-empty queue
    apply_reset();
    press(4'b0001);
    check("pre_reset_q", 32'(q_count), 32'd1);
    btn = 4'b0010;
    repeat (4) tick();
    reset = 1'b0;
    model_reset();
    #1;
    check("async_reset_outputs", 32'({direction, q_count, press_evt, turn_dropped}),
          32'({2'b01, QW'(0), 4'b0000, 1'b0}));
    btn = 4'b0000;
    repeat (2) tick();
    reset = 1'b1;
    repeat (10) tick();
    check("post_reset_q", 32'(q_count), 32'd0);
    check("post_reset_dir", 32'(direction), 32'(2'b01));

    // randomized traffic against the model
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 6) == 0) btn[b] = ~btn[b];
      step = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 799) == 0) begin
        btn  = 4'b0000;
        step = 1'b0;
        apply_reset();
      end
      tick();
    end
    btn  = 4'b0000;
    step = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
